adsr_envelope: RTL and testbench
================================

// Module: adsr_envelope
// PURPOSE
//  Per-note ADSR amplitude envelope between the tone recorder (8-bit signed PCM) and volume_control.
//  Shapes each sample by a time-varying level so notes fade in and out instead of hard-gating.
//  Steps once per sample strobe (~131,072 Hz); active_out drives the keyboard audio enable.
// PARAMETERS
//  ACC_W    16  envelope accumulator width; level = acc[ACC_W-1 -: 8]
//  RATE_W   12  width of attack/decay/release rate ports (acc delta per sample)
// PORTS
//  clk_in        in   1       100MHz system clock
//  rst_in        in   1       asynchronous, active-high reset
//  step_in       in   1       1-cycle sample strobe; all envelope updates occur only on these cycles
//  gate_in       in   1       note held (1) / released (0); any clk-rate level
//  note_in       in   7       current note index; change while gated retriggers attack
//  attack_in     in   RATE_W  acc increment per step in ATTACK; 0 = instantaneous
//  decay_in      in   RATE_W  acc decrement per step in DECAY; 0 = instantaneous
//  sustain_in    in   8       sustain level (0..255)
//  release_in    in   RATE_W  acc decrement per step in RELEASE; 0 = instantaneous
//  signal_in     in   8       signed PCM sample, sampled on step_in cycle
//  signal_out    out  8       signed shaped sample
//  valid_out     out  1       1-cycle pulse: signal_out updated
//  level_out     out  8       current envelope level
//  active_out    out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset (async, any time incl. mid-note): state=IDLE, acc=0, signal_out=0, valid_out=0,
//   level_out=0, active_out=0, trig_pend=0, note_q=0. Output regs clear on reset assertion.
//  Trigger capture (every clk): trig_pend<=1 on gate_in 0->1 edge, or on note_in!=note_q while
//   gate_in=1; note_q<=note_in each clk. trig_pend clears on the next step_in. A gate pulse that
//   starts and ends between strobes still produces one ATTACK step, then RELEASE.
//  FSM, evaluated only on step_in=1 (priority top-down):
//   trig_pend            -> ATTACK (acc continues from current value; no reset to 0 = no click)
//   !gate_in & state in {ATTACK,DECAY,SUSTAIN} -> RELEASE
//   ATTACK : acc+=attack_in, saturate at 2^ACC_W-1; on saturate (or attack_in=0) -> DECAY
//   DECAY  : acc-=decay_in; if result <= {sustain_in,8'h00} (or decay_in=0) acc={sustain_in,8'h00} -> SUSTAIN
//   SUSTAIN: acc={sustain_in,8'h00} every step (tracks live sustain_in changes)
//   RELEASE: acc-=release_in, saturate at 0; at 0 (or release_in=0) acc=0 -> IDLE
//   IDLE   : acc=0
//  Arithmetic: rates zero-extend to ACC_W; saturation is compare-before-write; no wrap-around.
//  Output: on step_in, prod = signal_in * $signed({1'b0,level}) (16-bit signed);
//   signal_out <= prod[15:8] (arithmetic >>>8), using the level BEFORE this step's acc update.
//   Latency: signal_out/valid_out update 1 clk after step_in; valid_out high exactly that cycle.
//  level_out = acc[ACC_W-1 -: 8], combinational from acc. active_out registered with state.
//  step_in held high on consecutive cycles: each cycle is a full step (no merging).
// STRUCTURE
//  adsr_pkg: typedef enum logic [2:0] {ENV_IDLE,ENV_ATTACK,ENV_DECAY,ENV_SUSTAIN,ENV_RELEASE}
//   env_state_t; localparams ENV_LVL_W=8, ENV_ACC_MAX.
//  Sub-module env_scaler: registered signed 8 x unsigned 8 multiply, >>>8, valid pass-through.
//  Top holds trigger capture, FSM and accumulator.
// TESTING (strobe every 764 clks unless noted)
//  1 reset mid-RELEASE (acc=0x8000): rst_in pulse -> same cycle signal_out=0, active_out=0, IDLE.
//  2 attack=0x100, decay=0x80, sustain=0x80, gate 0->1 -> 256 steps to acc=0xFFFF (DECAY),
//    then 256 steps to 0x8000 (SUSTAIN); level_out=0x80 held.
//  3 SUSTAIN, signal_in=+127 -> signal_out=63 (127*128>>8); signal_in=-128 -> -64; level 255,
//    -128 -> -128; level 0 -> 0.
//  4 gate 1->0 in SUSTAIN, release=0x40 -> 512 steps to IDLE, active_out falls with IDLE.
//  5 attack=decay=release=0: gate rise -> SUSTAIN in 2 steps; gate fall -> IDLE in 1 step.
//  6 gate pulse of 10 clks between strobes from IDLE -> one ATTACK step (acc=attack_in),
//    next step RELEASE; note_in change while gated in SUSTAIN -> ATTACK from 0x8000.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope.
package adsr_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    localparam int ENV_LVL_W = 8;
    localparam int ENV_ACC_W = 16;
    localparam logic [ENV_ACC_W-1:0] ENV_ACC_MAX = '1;

endpackage

// File: rtl/adsr_envelope_scaler.sv
// Registered signed-sample x unsigned-level multiply, floor-shifted by 8.
module env_scaler
    import adsr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0]           sample,
    input  logic [ENV_LVL_W-1:0] level,
    output logic [7:0]           scaled,
    output logic                 valid
);

    logic signed [15:0] prod;

    assign prod = $signed(sample) * $signed({1'b0, level});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scaled <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                scaled <= 8'(prod >>> 8);
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-note ADSR envelope: trigger capture, envelope FSM and accumulator.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int ACC_W  = ENV_ACC_W,
    parameter int RATE_W = 12
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              step_in,
    input  logic              gate_in,
    input  logic [6:0]        note_in,
    input  logic [RATE_W-1:0] attack_in,
    input  logic [RATE_W-1:0] decay_in,
    input  logic [7:0]        sustain_in,
    input  logic [RATE_W-1:0] release_in,
    input  logic [7:0]        signal_in,
    output logic [7:0]        signal_out,
    output logic              valid_out,
    output logic [7:0]        level_out,
    output logic              active_out
);

    localparam logic [ACC_W-1:0] ACC_MAX =
        (ACC_W == ENV_ACC_W) ? ACC_W'(ENV_ACC_MAX) : '1;
    localparam int PAD_W = ACC_W - RATE_W;

    env_state_t       state_q, state_d, eff;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] att_ext, dec_ext, rel_ext, sus_tgt;
    logic [ACC_W:0]   sum_w, lim_w;
    logic             gate_q, trig_pend, trig_now;
    logic [6:0]       note_q;

    assign att_ext = {{PAD_W{1'b0}}, attack_in};
    assign dec_ext = {{PAD_W{1'b0}}, decay_in};
    assign rel_ext = {{PAD_W{1'b0}}, release_in};
    assign sus_tgt = {sustain_in, {(ACC_W-ENV_LVL_W){1'b0}}};

    assign level_out = acc_q[ACC_W-1 -: ENV_LVL_W];

    assign trig_now = gate_in && (!gate_q || note_in != note_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            gate_q    <= 1'b0;
            note_q    <= '0;
            trig_pend <= 1'b0;
        end else begin
            gate_q <= gate_in;
            note_q <= note_in;
            if (trig_now) begin
                trig_pend <= 1'b1;
            end else if (step_in) begin
                trig_pend <= 1'b0;
            end
        end
    end

    // Overrides pick the state whose action this step performs.
    always_comb begin
        eff     = state_q;
        state_d = state_q;
        acc_d   = acc_q;
        sum_w   = {1'b0, acc_q} + {1'b0, att_ext};
        lim_w   = {1'b0, sus_tgt} + {1'b0, dec_ext};
        if (step_in) begin
            if (trig_pend) begin
                eff = ENV_ATTACK;
            end else if (!gate_in && (state_q == ENV_ATTACK ||
                         state_q == ENV_DECAY || state_q == ENV_SUSTAIN)) begin
                eff = ENV_RELEASE;
            end
            state_d = eff;
            unique case (eff)
                ENV_ATTACK: begin
                    if (attack_in == '0 || sum_w >= {1'b0, ACC_MAX}) begin
                        acc_d   = ACC_MAX;
                        state_d = ENV_DECAY;
                    end else begin
                        acc_d = sum_w[ACC_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (decay_in == '0 || {1'b0, acc_q} <= lim_w) begin
                        acc_d   = sus_tgt;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        acc_d = acc_q - dec_ext;
                    end
                end
                ENV_SUSTAIN: begin
                    acc_d = sus_tgt;
                end
                ENV_RELEASE: begin
                    if (release_in == '0 || acc_q <= rel_ext) begin
                        acc_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        acc_d = acc_q - rel_ext;
                    end
                end
                ENV_IDLE: begin
                    acc_d = '0;
                end
                default: begin
                    acc_d   = '0;
                    state_d = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ENV_IDLE;
            acc_q      <= '0;
            active_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            active_out <= (state_d != ENV_IDLE);
        end
    end

    env_scaler u_scaler (
        .clk    (clk_in),
        .rst    (rst_in),
        .en     (step_in),
        .sample (signal_in),
        .level  (level_out),
        .scaled (signal_out),
        .valid  (valid_out)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a per-cycle reference model.
module tb_adsr_envelope;

    localparam int PER = 8;
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        step_in = 1'b0;
    logic        gate_in = 1'b0;
    logic [6:0]  note_in = '0;
    logic [11:0] attack_in = '0;
    logic [11:0] decay_in = '0;
    logic [7:0]  sustain_in = '0;
    logic [11:0] release_in = '0;
    logic [7:0]  signal_in = '0;
    logic [7:0]  signal_out;
    logic        valid_out;
    logic [7:0]  level_out;
    logic        active_out;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_acc = 0;
    int         m_ph = P_IDLE;
    bit         m_pend = 0;
    bit         m_pg = 0;
    logic [6:0] m_pn = '0;
    logic [7:0] m_sig = '0;
    bit         m_valid = 0;

    adsr_envelope dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .step_in    (step_in),
        .gate_in    (gate_in),
        .note_in    (note_in),
        .attack_in  (attack_in),
        .decay_in   (decay_in),
        .sustain_in (sustain_in),
        .release_in (release_in),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .valid_out  (valid_out),
        .level_out  (level_out),
        .active_out (active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: envelope rules in plain integer arithmetic.
    initial begin
        int  ph, lvl, tgt;
        bit  trig;
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                m_acc = 0; m_ph = P_IDLE; m_pend = 0;
                m_pg = 0; m_pn = '0; m_sig = '0; m_valid = 0;
            end else begin
                trig = gate_in && (!m_pg || note_in != m_pn);
                m_valid = step_in;
                if (step_in) begin
                    lvl = m_acc / 256;
                    m_sig = 8'((int'($signed(signal_in)) * lvl) >>> 8);
                    ph = m_ph;
                    if (m_pend) ph = P_ATT;
                    else if (!gate_in && ph inside {P_ATT, P_DEC, P_SUS}) ph = P_REL;
                    tgt = int'(sustain_in) * 256;
                    case (ph)
                        P_ATT: begin
                            if (attack_in == 0 || m_acc + int'(attack_in) >= 65535) begin
                                m_acc = 65535; ph = P_DEC;
                            end else m_acc = m_acc + int'(attack_in);
                        end
                        P_DEC: begin
                            if (decay_in == 0 || m_acc - int'(decay_in) <= tgt) begin
                                m_acc = tgt; ph = P_SUS;
                            end else m_acc = m_acc - int'(decay_in);
                        end
                        P_SUS: m_acc = tgt;
                        P_REL: begin
                            if (release_in == 0 || m_acc - int'(release_in) <= 0) begin
                                m_acc = 0; ph = P_IDLE;
                            end else m_acc = m_acc - int'(release_in);
                        end
                        default: m_acc = 0;
                    endcase
                    m_ph = ph;
                end
                if (trig) m_pend = 1;
                else if (step_in) m_pend = 0;
                m_pg = gate_in;
                m_pn = note_in;
            end
            #1;
            chk("model_level", 16'(level_out), 16'(m_acc / 256));
            chk("model_active", 16'(active_out), 16'(m_ph != P_IDLE));
            chk("model_valid", 16'(valid_out), 16'(m_valid));
            chk("model_signal", 16'(signal_out), 16'(m_sig));
        end
    end

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            step_in = 1'b1;
            @(negedge clk_in);
            step_in = 1'b0;
            repeat (PER - 2) @(negedge clk_in);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_level", 16'(level_out), 16'h00);
        chk("rst_active", 16'(active_out), 16'h0);
        chk("rst_signal", 16'(signal_out), 16'h00);
        chk("rst_valid", 16'(valid_out), 16'h0);
        rst_in = 1'b0;
        note_in = 7'd7;
        @(negedge clk_in);

        // attack 0x100 / decay 0x80 / sustain 0x80
        attack_in = 12'h100; decay_in = 12'h080;
        sustain_in = 8'h80; release_in = 12'h040;
        gate_in = 1'b1;
        strobe(255);
        chk("att255_level", 16'(level_out), 16'hFF);
        strobe(1);
        chk("att256_level", 16'(level_out), 16'hFF);
        strobe(255);
        chk("dec255_level", 16'(level_out), 16'h80);
        strobe(1);
        chk("dec256_level", 16'(level_out), 16'h80);
        strobe(5);
        chk("sus_level", 16'(level_out), 16'h80);
        chk("sus_active", 16'(active_out), 16'h1);

        // scaling
        signal_in = 8'd127;
        strobe(1);
        chk("scale_p127", 16'(signal_out), 16'h3F);
        signal_in = 8'h80;
        strobe(1);
        chk("scale_m128", 16'(signal_out), 16'hC0);
        sustain_in = 8'hFF;
        strobe(1);
        strobe(1);
        chk("scale_l255", 16'(signal_out), 16'h80);
        sustain_in = 8'h00;
        strobe(2);
        chk("scale_l0", 16'(signal_out), 16'h00);
        sustain_in = 8'h80;
        strobe(1);
        chk("sus_back", 16'(level_out), 16'h80);

        // release 0x40 from 0x8000
        gate_in = 1'b0;
        strobe(511);
        chk("rel511_level", 16'(level_out), 16'h00);
        chk("rel511_active", 16'(active_out), 16'h1);
        strobe(1);
        chk("rel512_active", 16'(active_out), 16'h0);

        // instantaneous rates
        attack_in = '0; decay_in = '0; release_in = '0;
        gate_in = 1'b1;
        strobe(1);
        chk("inst_att", 16'(level_out), 16'hFF);
        strobe(1);
        chk("inst_dec", 16'(level_out), 16'h80);
        gate_in = 1'b0;
        strobe(1);
        chk("inst_rel_lvl", 16'(level_out), 16'h00);
        chk("inst_rel_act", 16'(active_out), 16'h0);

        // short gate pulse between strobes
        attack_in = 12'h300; decay_in = 12'h080; release_in = 12'h100;
        gate_in = 1'b1;
        repeat (10) @(negedge clk_in);
        gate_in = 1'b0;
        strobe(1);
        chk("pulse_att", 16'(level_out), 16'h03);
        chk("pulse_act", 16'(active_out), 16'h1);
        strobe(1);
        chk("pulse_rel1", 16'(level_out), 16'h02);
        strobe(2);
        chk("pulse_idle", 16'(active_out), 16'h0);

        // note change retriggers from sustain
        attack_in = '0; decay_in = '0;
        gate_in = 1'b1;
        strobe(2);
        chk("retrig_sus", 16'(level_out), 16'h80);
        attack_in = 12'h100;
        note_in = 7'd9;
        strobe(1);
        chk("retrig_att", 16'(level_out), 16'h81);

        // step held for three cycles
        @(negedge clk_in);
        step_in = 1'b1;
        repeat (3) @(negedge clk_in);
        step_in = 1'b0;
        chk("held_step", 16'(level_out), 16'h84);

        // async reset mid-release
        attack_in = '0;
        strobe(1);
        strobe(1);
        signal_in = 8'd100;
        gate_in = 1'b0; release_in = 12'h040;
        strobe(1);
        chk("prerst_signal", 16'(signal_out), 16'h32);
        chk("prerst_level", 16'(level_out), 16'h7F);
        @(posedge clk_in);
        #3 rst_in = 1'b1;
        #1;
        chk("async_signal", 16'(signal_out), 16'h00);
        chk("async_active", 16'(active_out), 16'h0);
        chk("async_level", 16'(level_out), 16'h00);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        attack_in = 12'h100;
        gate_in = 1'b1;
        strobe(1);
        chk("post_rst_att", 16'(level_out), 16'h01);
        repeat (4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
